irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: seven-level, edge-triggered interrupt controller with a mask register
// and an ack handshake toward a core.
//
// IRQ[k] raises priority level k+1 (level 7 is the highest). A rising edge on IRQ[k]
// sets PEND[k]. The highest pending, unmasked level is presented on OINT_n, which is
// active-low and registered. A presented level can be preempted upward, but never
// downward. An ack (IACK_n=0) while presenting clears the presented pending bit. It
// then forces one idle GAP cycle before the next request is presented.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   IRQ[6:0]   in   interrupt sources
//   IACK_n     in   core acknowledge, active-low
//   mask_we    in   mask write strobe
//   mask_wdata in   new mask value (bit k=1 enables IRQ[k])
//   OINT_n     out  active-low encoded level, 3'b111 = no request
//   PEND[6:0]  out  pending register
//   MASK[6:0]  out  mask register
//
// Build option: define IRQ_CTRL_SYNC_EN to place a 2-flop synchronizer on each IRQ bit
// ahead of edge detection. This adds two cycles of latency.
module irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] IRQ,
  input  logic       IACK_n,
  input  logic       mask_we,
  input  logic [6:0] mask_wdata,
  output logic [2:0] OINT_n,
  output logic [6:0] PEND,
  output logic [6:0] MASK
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e     state_q, state_d;
  logic [2:0] lvl_q, lvl_d;
  logic [2:0] oint_q, oint_d;
  logic [6:0] pend_q, pend_d;
  logic [6:0] mask_q;
  logic [6:0] irq_prev_q;
  logic [6:0] irq_s;
  logic [6:0] eff;
  logic [6:0] clr;
  logic [2:0] lvl;

`ifdef IRQ_CTRL_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= IRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = IRQ;
`endif

  assign eff = pend_q & mask_q;

  // Priority encode: the highest set bit wins, and 0 means nothing is eligible.
  always_comb begin
    lvl = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (eff[k]) lvl = 3'(k + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    oint_d  = 3'b111;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (eff != '0) begin
          state_d = StReq;
          lvl_d   = lvl;
          oint_d  = ~lvl;
        end
      end
      StReq: begin
        // An ack refers to the level on OINT_n this cycle, which is lvl_q. The ack
        // takes precedence over a withdrawal that is first seen in the same cycle.
        if (!IACK_n) begin
          clr     = 7'b1 << (lvl_q - 3'd1);
          state_d = StGap;
        end else if (eff == '0) begin
          state_d = StIdle;
        end else begin
          if (lvl > lvl_q) lvl_d = lvl;
          oint_d = (lvl > lvl_q) ? ~lvl : ~lvl_q;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // When an edge sets a bit in the same cycle as an ack clears it, the set wins.
  assign pend_d = (pend_q & ~clr) | (irq_s & ~irq_prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lvl_q      <= 3'd0;
      oint_q     <= 3'b111;
      pend_q     <= '0;
      mask_q     <= 7'h7F;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      oint_q     <= oint_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_s;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign OINT_n = oint_q;
  assign PEND   = pend_q;
  assign MASK   = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl. It runs directed scenarios with literal expectations, followed by
// randomized traffic. A behavioural model checks the outputs on every cycle.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] IRQ = '0;
  logic       IACK_n = 1'b1;
  logic       mask_we = 1'b0;
  logic [6:0] mask_wdata = '0;
  logic [2:0] OINT_n;
  logic [6:0] PEND;
  logic [6:0] MASK;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  irq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .IRQ       (IRQ),
    .IACK_n    (IACK_n),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .OINT_n    (OINT_n),
    .PEND      (PEND),
    .MASK      (MASK)
  );

  always #5 clk = ~clk;

  // Model state. m_lvl is the level being presented (0 = none). m_gap is set for the
  // one quiet cycle that follows an ack.
  logic [6:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  int         m_lvl;
  bit         m_gap;

  always @(posedge clk) begin
    logic [6:0] s, edges, eff, clr;
    int top;
    if (rst) begin
      m_pend = '0; m_mask = 7'h7F; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_lvl = 0; m_gap = 1'b0;
    end else begin
`ifdef IRQ_CTRL_SYNC_EN
      s = m_s2; m_s2 = m_s1; m_s1 = IRQ;
`else
      s = IRQ;
`endif
      edges = s & ~m_prev;
      m_prev = s;
      eff = m_pend & m_mask;
      top = 0;
      for (int k = 0; k < 7; k++) if (eff[k]) top = k + 1;
      clr = '0;
      if (m_lvl != 0 && !IACK_n) begin
        clr[m_lvl-1] = 1'b1;
        m_lvl = 0;
        m_gap = 1'b1;
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (top == 0) begin
        m_lvl = 0;
      end else if (top > m_lvl) begin
        m_lvl = top;
      end
      m_pend = (m_pend & ~clr) | edges;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model OINT_n", {4'b0, OINT_n}, {4'b0, 3'(7 - m_lvl)});
      chk("model PEND", PEND, m_pend);
      chk("model MASK", MASK, m_mask);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ack();
    IACK_n = 1'b0;
    tick();
    IACK_n = 1'b1;
  endtask

  initial begin
    tick();
    started = 1'b1;
    chk("reset OINT_n", {4'b0, OINT_n}, 7'h07);
    chk("reset PEND", PEND, 7'h00);
    chk("reset MASK", MASK, 7'h7F);
    rst = 1'b0;

    // Single request on IRQ[2].
    IRQ = 7'h04; tick(); IRQ = '0;
    repeat (Lat - 2) tick();
    chk("single PEND set", PEND, 7'h04);
    chk("single OINT_n idle", {4'b0, OINT_n}, 7'h07);
    tick();
    chk("single OINT_n lvl3", {4'b0, OINT_n}, 7'h04);
    ack();
    chk("single PEND clr", PEND, 7'h00);
    chk("single OINT_n gap", {4'b0, OINT_n}, 7'h07);
    tick(); tick();
    chk("single OINT_n stays", {4'b0, OINT_n}, 7'h07);

    // Preemption: level 2 first, then level 7.
    IRQ = 7'h02; tick(); IRQ = '0;
    repeat (Lat - 1) tick();
    chk("preempt lvl2", {4'b0, OINT_n}, 7'h05);
    IRQ = 7'h40; tick(); IRQ = '0;
    repeat (Lat - 1) tick();
    chk("preempt lvl7", {4'b0, OINT_n}, 7'h00);
    ack();
    chk("preempt PEND", PEND, 7'h02);
    tick();
    chk("preempt gap", {4'b0, OINT_n}, 7'h07);
    tick();
    chk("preempt back lvl2", {4'b0, OINT_n}, 7'h05);
    ack(); tick(); tick();

    // Masking and withdrawal.
    mask_we = 1'b1; mask_wdata = 7'h00; tick(); mask_we = 1'b0;
    IRQ = 7'h08; tick(); IRQ = '0;
    repeat (Lat) tick();
    chk("mask PEND held", PEND, 7'h08);
    chk("mask OINT_n off", {4'b0, OINT_n}, 7'h07);
    mask_we = 1'b1; mask_wdata = 7'h08; tick(); mask_we = 1'b0;
    tick();
    chk("unmask lvl4", {4'b0, OINT_n}, 7'h03);
    mask_we = 1'b1; mask_wdata = 7'h00; tick(); mask_we = 1'b0;
    tick();
    chk("withdraw OINT_n", {4'b0, OINT_n}, 7'h07);
    chk("withdraw PEND", PEND, 7'h08);

    // Reset while presenting, then an ack while idle.
    mask_we = 1'b1; mask_wdata = 7'h7F; tick(); mask_we = 1'b0;
    tick();
    chk("pre-reset lvl4", {4'b0, OINT_n}, 7'h03);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midreset OINT_n", {4'b0, OINT_n}, 7'h07);
    chk("midreset PEND", PEND, 7'h00);
    chk("midreset MASK", MASK, 7'h7F);
    IACK_n = 1'b0; tick(); tick(); IACK_n = 1'b1;
    chk("spurious ack PEND", PEND, 7'h00);
    chk("spurious ack OINT_n", {4'b0, OINT_n}, 7'h07);

    // Collision: IRQ[0] edge lands on the same clock edge as its own ack.
    IRQ = 7'h01; tick(); IRQ = '0;
    repeat (Lat - 1) tick();
    chk("collide lvl1", {4'b0, OINT_n}, 7'h06);
    IRQ = 7'h01;
    if (Lat == 4) begin
      tick(); IRQ = '0; tick();
    end
    IACK_n = 1'b0; tick(); IACK_n = 1'b1; IRQ = '0;
    chk("collide PEND kept", PEND, 7'h01);
    tick();
    chk("collide gap", {4'b0, OINT_n}, 7'h07);
    tick();
    chk("collide re-present", {4'b0, OINT_n}, 7'h06);
    ack(); tick(); tick();

    // Randomized traffic, checked only against the model.
    for (int i = 0; i < 4000; i++) begin
      IRQ = IRQ ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
      IACK_n = ($urandom_range(0, 3) != 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wdata = 7'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; IACK_n = 1'b1; mask_we = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
